// File: rtl/vga_mode_seq_if.sv
// Signal bundle between the VGA frame sequencer and the timing driver / rgb stages.
// With VGA_SEQ_PAUSE_EN defined, a pause input is added to the bundle.
interface vga_mode_seq_if;
  logic        vsync;
  logic        key_n;
  logic [1:0]  mode;
  logic        auto_mode;
  logic [10:0] box_x;
  logic [9:0]  box_y;
  logic        frame_tick;
`ifdef VGA_SEQ_PAUSE_EN
  logic        pause;
`endif

  modport master (
`ifdef VGA_SEQ_PAUSE_EN
    input  pause,
`endif
    input  vsync,
    input  key_n,
    output mode,
    output auto_mode,
    output box_x,
    output box_y,
    output frame_tick
  );

  modport slave (
`ifdef VGA_SEQ_PAUSE_EN
    output pause,
`endif
    output vsync,
    output key_n,
    input  mode,
    input  auto_mode,
    input  box_x,
    input  box_y,
    input  frame_tick
  );
endinterface

// File: rtl/vga_mode_seq.sv
// Frame-level mode/box sequencer for the 800x600@60 path; updates only at vsync start.
// Optional VGA_SEQ_PAUSE_EN freezes box motion and the auto frame counter while pause=1.
module vga_mode_seq #(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 600,
  parameter int BOX_W       = 64,
  parameter int BOX_H       = 48,
  parameter int STEP        = 2,
  parameter int AUTO_FRAMES = 180,
  parameter int DEB_CYCLES  = 800000,
  parameter int LONG_CYCLES = 40000000,
  parameter int VS_POL      = 1
) (
  input logic           clk,
  input logic           rst_n,
  vga_mode_seq_if.master bus
);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [15:0]       AF_LAST   = 16'(AUTO_FRAMES - 1);
  localparam logic [11:0]       XMAX      = 12'(H_ACT - BOX_W);
  localparam logic [11:0]       XSTEP     = 12'(STEP);
  localparam logic [10:0]       YMAX      = 11'(V_ACT - BOX_H);
  localparam logic [10:0]       YSTEP     = 11'(STEP);
  localparam logic              VS_ACT    = (VS_POL != 0);

  typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

  // key path
  logic [1:0]        sync_reg;
  logic              deb_reg;
  logic [DEB_W-1:0]  deb_cnt_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic              deb_flip, pressed, short_evt, long_evt;

  // frame path
  logic        vs_reg, tick_reg, tick_now, run, auto_adv;
  state_t      state_reg, state_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic        pend_reg, pend_next;
  logic [1:0]  mode_reg, mode_next;
  logic [10:0] x_reg, x_next, x_dif;
  logic [9:0]  y_reg, y_next, y_dif;
  logic [11:0] x_sum;
  logic [10:0] y_sum;
  logic        xdir_reg, xdir_next, ydir_reg, ydir_next;

  assign deb_flip  = (sync_reg[1] != deb_reg) && (deb_cnt_reg == DEB_LAST);
  assign pressed   = !deb_reg;
  assign long_evt  = pressed && (hold_reg == LONG_LAST);
  // A release in the same cycle the hold limit is hit counts as long only
  assign short_evt = deb_flip && pressed && (hold_reg < LONG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= 2'b11;
      deb_reg     <= 1'b1;
      deb_cnt_reg <= '0;
      hold_reg    <= '0;
    end else begin
      sync_reg <= {sync_reg[0], bus.key_n};
      if (sync_reg[1] == deb_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_flip) begin
        deb_reg     <= sync_reg[1];
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
      if (!pressed) begin
        hold_reg <= '0;
      end else if (hold_reg != LONG_MAX) begin
        hold_reg <= hold_reg + 1'b1;
      end
    end
  end

  assign tick_now = (bus.vsync == VS_ACT) && (vs_reg != VS_ACT);
`ifdef VGA_SEQ_PAUSE_EN
  assign run = !bus.pause;
`else
  assign run = 1'b1;
`endif

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    pend_next      = pend_reg;
    mode_next      = mode_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    xdir_next      = xdir_reg;
    ydir_next      = ydir_reg;
    auto_adv       = 1'b0;
    x_sum          = {1'b0, x_reg} + XSTEP;
    y_sum          = {1'b0, y_reg} + YSTEP;
    x_dif          = x_reg - XSTEP[10:0];
    y_dif          = y_reg - YSTEP[9:0];

    if (tick_now && run) begin
      if (state_reg == ST_AUTO) begin
        if (frame_cnt_reg == AF_LAST) begin
          frame_cnt_next = '0;
          auto_adv       = 1'b1;
        end else if (pend_reg || short_evt) begin
          frame_cnt_next = '0;
        end else begin
          frame_cnt_next = frame_cnt_reg + 16'd1;
        end
      end else begin
        frame_cnt_next = '0;
      end

      if (xdir_reg) begin
        if (x_sum >= XMAX) begin
          x_next    = XMAX[10:0];
          xdir_next = 1'b0;
        end else begin
          x_next = x_sum[10:0];
        end
      end else if ({1'b0, x_reg} <= XSTEP) begin
        x_next    = '0;
        xdir_next = 1'b1;
      end else begin
        x_next = x_dif;
      end

      if (ydir_reg) begin
        if (y_sum >= YMAX) begin
          y_next    = YMAX[9:0];
          ydir_next = 1'b0;
        end else begin
          y_next = y_sum[9:0];
        end
      end else if ({1'b0, y_reg} <= YSTEP) begin
        y_next    = '0;
        ydir_next = 1'b1;
      end else begin
        y_next = y_dif;
      end
    end

    // Any number of causes within one frame yields a single step
    if (tick_now && (pend_reg || short_evt || auto_adv)) begin
      mode_next = mode_reg + 2'd1;
    end
    if (tick_now) begin
      pend_next = 1'b0;
    end else if (short_evt) begin
      pend_next = 1'b1;
    end

    if (long_evt) begin
      state_next     = (state_reg == ST_AUTO) ? ST_MANUAL : ST_AUTO;
      frame_cnt_next = '0;
      pend_next      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_reg        <= !VS_ACT;
      tick_reg      <= 1'b0;
      state_reg     <= ST_AUTO;
      frame_cnt_reg <= '0;
      pend_reg      <= 1'b0;
      mode_reg      <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      xdir_reg      <= 1'b1;
      ydir_reg      <= 1'b1;
    end else begin
      vs_reg        <= bus.vsync;
      tick_reg      <= tick_now;
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      pend_reg      <= pend_next;
      mode_reg      <= mode_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      xdir_reg      <= xdir_next;
      ydir_reg      <= ydir_next;
    end
  end

  assign bus.mode       = mode_reg;
  assign bus.auto_mode  = (state_reg == ST_AUTO);
  assign bus.box_x      = x_reg;
  assign bus.box_y      = y_reg;
  assign bus.frame_tick = tick_reg;
endmodule

// File: tb/tb_vga_mode_seq.sv
// Directed bench for vga_mode_seq: frame ticks, debounced short/long presses, mode stepping,
// box bounce at the right/bottom edges and asynchronous reset during a held press.
module tb_vga_mode_seq;
  logic clk;
  logic rst_n;
  vga_mode_seq_if bus ();

  vga_mode_seq #(
    .AUTO_FRAMES(3),
    .DEB_CYCLES (4),
    .LONG_CYCLES(50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int vs_period = 200;
  bit vs_en = 0;
  int vs_ph = 0;
  int tick_cnt = 0, short_cnt = 0, long_cnt = 0;
  int wide_cnt = 0, off_tick_cnt = 0;
  logic       prev_tick = 0;
  logic [1:0] prev_mode = 0;
  logic [10:0] prev_x = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // vsync source: 4-cycle active pulse every vs_period cycles
  initial begin
    bus.vsync = 0;
    forever begin
      @(posedge clk);
      #1;
      if (vs_en) begin
        vs_ph = (vs_ph + 1 >= vs_period) ? 0 : vs_ph + 1;
        bus.vsync = (vs_ph < 4);
      end else begin
        vs_ph = 0;
        bus.vsync = 0;
      end
    end
  end

  // Event monitor: tick count/width, internal press events, changes off the tick
  always @(negedge clk) begin
    if (!rst_n) begin
      tick_cnt = 0; short_cnt = 0; long_cnt = 0;
      prev_tick = 0; prev_mode = 0; prev_x = 0;
    end else begin
      if (bus.frame_tick) begin
        tick_cnt++;
        if (prev_tick) wide_cnt++;
      end else if (bus.mode != prev_mode || bus.box_x != prev_x) begin
        off_tick_cnt++;
      end
      if (dut.short_evt) short_cnt++;
      if (dut.long_evt) long_cnt++;
      prev_tick = bus.frame_tick;
      prev_mode = bus.mode;
      prev_x    = bus.box_x;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int target = tick_cnt + n;
    for (int i = 0; i < n * vs_period + 50 && tick_cnt < target; i++) sample();
    check("tick_arrived", int'(tick_cnt >= target), 1);
  endtask

  task automatic press(input int low_cycles, input bit bounce);
    if (bounce) begin
      bus.key_n = 0; cyc(2);
      bus.key_n = 1; cyc(2);
    end
    bus.key_n = 0; cyc(low_cycles);
    if (bounce) begin
      bus.key_n = 1; cyc(2);
      bus.key_n = 0; cyc(2);
    end
    bus.key_n = 1; cyc(12);
  endtask

  task automatic check_outs(input string tag, input int m, input int a, input int x, input int y);
    check({tag, ".mode"},  int'(bus.mode), m);
    check({tag, ".auto"},  int'(bus.auto_mode), a);
    check({tag, ".box_x"}, int'(bus.box_x), x);
    check({tag, ".box_y"}, int'(bus.box_y), y);
  endtask

  initial begin
    rst_n = 0;
    bus.key_n = 1;
`ifdef VGA_SEQ_PAUSE_EN
    bus.pause = 0;
`endif
    cyc(3);
    check_outs("reset", 0, 1, 0, 0);
    check("reset.tick", int'(bus.frame_tick), 0);
    rst_n = 1;
    cyc(2);
    vs_en = 1;

    // three frames in AUTO: step to mode 1, box at (6,6)
    wait_ticks(1);
    check_outs("frame1", 0, 1, 2, 2);
    wait_ticks(2);
    check_outs("frame3", 1, 1, 6, 6);
    check("frame3.count", tick_cnt, 3);

    // long press enters MANUAL, no mode step on release
    press(60, 0);
    check("long1.evt", long_cnt, 1);
    check("long1.short", short_cnt, 0);
    check("long1.auto", int'(bus.auto_mode), 0);
    check("long1.mode", int'(bus.mode), 1);
    wait_ticks(6);
    check("manual6.mode", int'(bus.mode), 1);
    check("manual6.auto", int'(bus.auto_mode), 0);

    // bouncy short press in MANUAL: one event, mode steps at next tick only
    press(20, 1);
    check("short.evt", short_cnt, 1);
    check("short.mode_pre", int'(bus.mode), 1);
    wait_ticks(1);
    check("short.mode_tick", int'(bus.mode), 2);

    // two short presses within one frame: single step
    press(10, 0);
    press(10, 0);
    check("dbl.evt", short_cnt, 3);
    check("dbl.mode_pre", int'(bus.mode), 2);
    wait_ticks(1);
    check("dbl.mode_tick", int'(bus.mode), 3);
    wait_ticks(1);
    check("dbl.mode_next", int'(bus.mode), 3);

    // wrap 3 -> 0
    press(10, 0);
    wait_ticks(1);
    check("wrap.mode", int'(bus.mode), 0);

    // long press back to AUTO: frame counter restarts, step at third tick
    press(60, 0);
    check("long2.evt", long_cnt, 2);
    check("long2.short", short_cnt, 4);
    check("long2.auto", int'(bus.auto_mode), 1);
    wait_ticks(2);
    check("auto2.mode", int'(bus.mode), 0);
    wait_ticks(1);
    check("auto3.mode", int'(bus.mode), 1);
    check("auto3.box_x", int'(bus.box_x), 32);

    // box bounce: bottom edge at tick 276, right edge at tick 368
    vs_period = 20;
    wait_ticks(276 - tick_cnt);
    check("t276.box_y", int'(bus.box_y), 552);
    check("t276.box_x", int'(bus.box_x), 552);
    wait_ticks(367 - tick_cnt);
    check("t367.box_x", int'(bus.box_x), 734);
    check("t367.box_y", int'(bus.box_y), 370);
    wait_ticks(1);
    check("t368.box_x", int'(bus.box_x), 736);
    check("t368.box_y", int'(bus.box_y), 368);
    wait_ticks(1);
    check("t369.box_x", int'(bus.box_x), 734);
    check("t369.box_y", int'(bus.box_y), 366);

    // async reset during a held press, mid-frame
    vs_en = 0;
    cyc(5);
    bus.key_n = 0;
    cyc(30);
    rst_n = 0;
    #1;
    check_outs("rst_mid", 0, 1, 0, 0);
    check("rst_mid.tick", int'(bus.frame_tick), 0);
    cyc(3);
    rst_n = 1;
    cyc(1);
    bus.key_n = 1;
    cyc(100);
    check("rst_after.short", short_cnt, 0);
    check("rst_after.long", long_cnt, 0);
    check_outs("rst_after", 0, 1, 0, 0);

    check("tick_width", wide_cnt, 0);
    check("change_off_tick", off_tick_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
